pc_word_tx: RTL and testbench

//  Parametrised word-to-UART transmitter for the PC link: buffers N-byte words from the DataRouter in a FIFO,

---
 rtl/pc_tx_pkg.sv | 22 ++
 rtl/pc_word_tx_fifo.sv | 67 ++++++
 rtl/pc_word_tx.sv | 186 ++++++++++++++++++
 tb/tb_pc_word_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_tx_pkg.sv
// Shared definitions for the PC-link word transmitter: FSM encodings, UART constants, parity helper.
// The PARITY encoding is only reached when PC_WORD_TX_PARITY_EN is defined.
package pc_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5,
        ST_NEXT   = 3'd6
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

    function automatic logic even_parity(input logic [7:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/pc_word_tx_fifo.sv
// Synchronous word FIFO with occupancy level and a one-cycle overflow pulse.
// Writes while full are dropped even if a pop happens in the same cycle.
module pc_word_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_push_valid,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty    = (r_level == {(PTR_W+1){1'b0}});
    assign w_push     = i_push_valid && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head     = r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers (wrap naturally at the power-of-2 depth), level and overflow flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_level    <= {(PTR_W+1){1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push_valid && o_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pc_word_tx.sv
// Word-to-UART transmitter: FIFO-buffered N-byte words framed as 8N1/8N2 bytes on a registered TX line.
// Define PC_WORD_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module pc_word_tx #(
    parameter int WORD_BYTES   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 435,
    parameter int STOP_BITS    = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [8*WORD_BYTES-1:0]     i_word_data,
    input  logic                        i_word_valid,
    input  logic                        i_msb_first,
    output logic                        o_word_ready,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_tx_busy,
    output logic                        o_UART_TX
);

    import pc_tx_pkg::*;

    localparam int WORD_W    = 8 * WORD_BYTES;
    localparam int BIT_CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t                   r_state;
    tx_state_t                   w_next_state;
    logic [BIT_CNT_W-1:0]        r_bit_cnt;
    logic [2:0]                  r_bit_idx;
    logic [3:0]                  r_byte_idx;
    logic [WORD_W-1:0]           r_word;
    logic [7:0]                  r_byte;
    logic                        r_msb_first;
    logic                        r_line;
    logic                        w_line_next;
    logic                        w_pop;
    logic                        w_bit_end;
    logic                        w_timing;
    logic [3:0]                  w_sel;
    logic [7:0]                  w_sel_byte;
    logic [WORD_W-1:0]           w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_level;

    pc_word_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_push_data  (i_word_data),
        .i_push_valid (i_word_valid),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_level      (w_level),
        .o_overflow   (o_overflow)
    );

    assign o_word_ready = !w_full;
    assign o_fifo_level = w_level;
    assign o_tx_busy    = (r_state != ST_IDLE) || (|w_level);
    assign o_UART_TX    = r_line;

    assign w_bit_end = (r_bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
    assign w_timing  = (r_state == ST_START) || (r_state == ST_DATA) ||
                       (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign w_sel     = r_msb_first ? (4'(WORD_BYTES - 1) - r_byte_idx) : r_byte_idx;

    // Byte selector over the latched word.
    always_comb begin
        w_sel_byte = 8'h00;
        for (int b = 0; b < WORD_BYTES; b++) begin
            w_sel_byte = (w_sel == 4'(b)) ? r_word[8*b +: 8] : w_sel_byte;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, FIFO pop and next line level.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_line_next  = IDLE_LEVEL;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_START;
            end
            ST_START: begin
                w_line_next  = 1'b0;
                w_next_state = w_bit_end ? ST_DATA : ST_START;
            end
            ST_DATA: begin
                w_line_next = r_byte[r_bit_idx];
                if (w_bit_end && (r_bit_idx == 3'(UART_DATA_BITS - 1))) begin
`ifdef PC_WORD_TX_PARITY_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_STOP;
`endif
                end else begin
                    w_next_state = ST_DATA;
                end
            end
`ifdef PC_WORD_TX_PARITY_EN
            ST_PARITY: begin
                w_line_next  = even_parity(r_byte);
                w_next_state = w_bit_end ? ST_STOP : ST_PARITY;
            end
`endif
            ST_STOP: begin
                w_line_next = 1'b1;
                if (w_bit_end && (r_bit_idx == 3'(STOP_BITS - 1))) begin
                    w_next_state = ST_NEXT;
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            ST_NEXT: begin
                if (r_byte_idx != 4'(WORD_BYTES - 1)) begin
                    w_next_state = ST_LOAD;
                end else if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: bit timer, bit/byte indices, latched word/byte and the registered line.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt   <= {BIT_CNT_W{1'b0}};
            r_bit_idx   <= 3'd0;
            r_byte_idx  <= 4'd0;
            r_word      <= {WORD_W{1'b0}};
            r_byte      <= 8'h00;
            r_msb_first <= 1'b0;
            r_line      <= IDLE_LEVEL;
        end else begin
            r_line    <= w_line_next;
            r_bit_cnt <= (w_timing && !w_bit_end) ? r_bit_cnt + 1'b1 : {BIT_CNT_W{1'b0}};
            // The index counts data bits in DATA and stop bits in STOP; it restarts on every state change.
            if (r_state != w_next_state) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_end && ((r_state == ST_DATA) || (r_state == ST_STOP))) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            if (w_pop) begin
                r_word      <= w_head;
                r_msb_first <= i_msb_first;
                r_byte_idx  <= 4'd0;
            end else if (r_state == ST_NEXT) begin
                r_byte_idx <= r_byte_idx + 4'd1;
            end else begin
                r_byte_idx <= r_byte_idx;
            end
            r_byte <= (r_state == ST_LOAD) ? w_sel_byte : r_byte;
        end
    end

endmodule

// File: tb/tb_pc_word_tx.sv
// Self-checking bench for pc_word_tx: table of words/byte orders plus hand-timed FIFO, overflow and reset sequences.
`timescale 1ns/1ps
module tb_pc_word_tx;

    localparam int WB    = 4;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int SB    = 1;
`ifdef PC_WORD_TX_PARITY_EN
    localparam int PBIT  = 1;
`else
    localparam int PBIT  = 0;
`endif
    localparam int BYTE_CYC = (10 + SB - 1 + PBIT) * CPB + 2;
    localparam int WORD_CYC = WB * BYTE_CYC;

    typedef struct {
        logic [31:0] word;
        logic        msb;
        logic [31:0] seq;   // expected bytes on the line, first byte in bits [31:24]
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_data = 32'h0;
    logic        word_valid = 1'b0;
    logic        msb_first = 1'b0;
    logic        word_ready;
    logic        overflow;
    logic [2:0]  fifo_level;
    logic        tx_busy;
    logic        uart_tx;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ovf_cnt = 0;
    int          rx_stop_err = 0;
    logic [7:0]  rx_q[$];
    logic        rx_par_q[$];
    int          rx_starts[$];

    pc_word_tx #(
        .WORD_BYTES   (WB),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (SB)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_word_data  (word_data),
        .i_word_valid (word_valid),
        .i_msb_first  (msb_first),
        .o_word_ready (word_ready),
        .o_overflow   (overflow),
        .o_fifo_level (fifo_level),
        .o_tx_busy    (tx_busy),
        .o_UART_TX    (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // UART receiver sampling mid-bit on falling clock edges (CPB=4).
    initial begin : rx_proc
        logic       active;
        int         cnt;
        logic [7:0] sh;
        active = 1'b0;
        cnt = 0;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (!active) begin
                if (uart_tx == 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt >= 5 && cnt <= 33 && (cnt % 4) == 1) sh[(cnt - 5) / 4] = uart_tx;
                if (PBIT == 1 && cnt == 37) rx_par_q.push_back(uart_tx);
                if (cnt == 37 + 4 * PBIT) begin
                    if (uart_tx !== 1'b1) rx_stop_err++;
                    rx_q.push_back(sh);
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : ovf_mon
        forever begin
            @(negedge clk);
            if (overflow === 1'b1) ovf_cnt++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [31:0] d);
        word_data  = d;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, rx_q.size(), n);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (tx_busy && k < WORD_CYC + 50) begin
            @(negedge clk);
            k++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    task automatic check_words(input logic [31:0] words[$], input string name);
        for (int w = 0; w < words.size(); w++) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_w%0d_b%0d", name, w, i), rx_q[4*w + i], words[w][8*i +: 8]);
            end
        end
    endtask

    initial begin : main
        vec_t        vecs[6];
        logic [31:0] words[$];
        int          nb;
        int          n_starts;

        vecs[0] = '{32'h4433_2211, 1'b0, 32'h1122_3344};
        vecs[1] = '{32'h4433_2211, 1'b1, 32'h4433_2211};
        vecs[2] = '{32'hA5C3_0F81, 1'b0, 32'h810F_C3A5};
        vecs[3] = '{32'h00FF_7E01, 1'b1, 32'h00FF_7E01};
        vecs[4] = '{32'h8000_0001, 1'b0, 32'h0100_0080};
        vecs[5] = '{32'h5AA5_C33C, 1'b1, 32'h5AA5_C33C};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_line", uart_tx, 1'b1);
        check("rst_ready", word_ready, 1'b1);
        check("rst_overflow", overflow, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_busy", tx_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Latency and frame length for a single word into an idle FIFO
        rx_q.delete();
        rx_starts.delete();
        msb_first = 1'b0;
        push(32'h4433_2211);
        check("lat_level_k", fifo_level, 3'd1);
        check("lat_busy_k", tx_busy, 1'b1);
        check("lat_line_k", uart_tx, 1'b1);
        @(negedge clk);
        check("lat_level_k1", fifo_level, 3'd0);
        check("lat_line_k1", uart_tx, 1'b1);
        @(negedge clk);
        check("lat_line_k2", uart_tx, 1'b1);
        @(negedge clk);
        check("lat_line_k3", uart_tx, 1'b0);
        nb = 4;
        for (int j = 0; j < WORD_CYC + 50 && tx_busy; j++) begin
            @(negedge clk);
            if (tx_busy) nb++;
        end
        check("frame_busy_cycles", nb, WORD_CYC + 1);
        check("frame_bytes", rx_q.size(), 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("byte_spacing%0d", i), rx_starts[i+1] - rx_starts[i], BYTE_CYC);
        end

        // Table: byte order, i_msb_first flipped right after the pop to show it is latched
        for (int v = 0; v < 6; v++) begin
            rx_q.delete();
            msb_first = vecs[v].msb;
            push(vecs[v].word);
            @(negedge clk);
            msb_first = ~vecs[v].msb;
            wait_bytes(4, WORD_CYC + 20, $sformatf("vec%0d_count", v));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("vec%0d_byte%0d", v, i), rx_q[i], vecs[v].seq[31 - 8*i -: 8]);
            end
            wait_idle($sformatf("vec%0d_idle", v));
        end

        // Overflow: one word in flight, then 5 back-to-back writes; the 5th is dropped
        rx_q.delete();
        msb_first = 1'b0;
        ovf_cnt = 0;
        push(32'hA3A2_A1A0);
        repeat (3) @(negedge clk);
        word_valid = 1'b1;
        word_data = 32'hB3B2_B1B0;
        @(negedge clk);
        check("ovf_level1", fifo_level, 3'd1);
        word_data = 32'hC3C2_C1C0;
        @(negedge clk);
        check("ovf_level2", fifo_level, 3'd2);
        word_data = 32'hD3D2_D1D0;
        @(negedge clk);
        word_data = 32'hE3E2_E1E0;
        @(negedge clk);
        check("ovf_level4", fifo_level, 3'd4);
        check("ovf_ready_full", word_ready, 1'b0);
        check("ovf_no_pulse_yet", overflow, 1'b0);
        word_data = 32'hF3F2_F1F0;
        @(negedge clk);
        word_valid = 1'b0;
        check("ovf_pulse", overflow, 1'b1);
        check("ovf_level_held", fifo_level, 3'd4);
        @(negedge clk);
        check("ovf_pulse_end", overflow, 1'b0);
        wait_bytes(20, 5 * WORD_CYC + 50, "ovf_count");
        words = '{32'hA3A2_A1A0, 32'hB3B2_B1B0, 32'hC3C2_C1C0, 32'hD3D2_D1D0, 32'hE3E2_E1E0};
        check_words(words, "ovf");
        wait_idle("ovf_idle");
        check("ovf_pulses", ovf_cnt, 1);

        // Push and pop in the same cycle at level 2, then pointer wrap over 6 words
        rx_q.delete();
        push(32'h1312_1110);
        @(negedge clk);
        push(32'h2322_2120);
        push(32'h3332_3130);
        check("pp_level_pre", fifo_level, 3'd2);
        repeat (WORD_CYC - 3) @(negedge clk);
        check("pp_level_before_pop", fifo_level, 3'd2);
        push(32'h4342_4140);
        check("pp_level_same_cycle", fifo_level, 3'd2);
        push(32'h5352_5150);
        check("pp_level3", fifo_level, 3'd3);
        push(32'h6362_6160);
        check("pp_level4", fifo_level, 3'd4);
        wait_bytes(24, 6 * WORD_CYC + 50, "wrap_count");
        words = '{32'h1312_1110, 32'h2322_2120, 32'h3332_3130,
                  32'h4342_4140, 32'h5352_5150, 32'h6362_6160};
        check_words(words, "wrap");
        wait_idle("wrap_idle");

        // Reset during DATA of byte 2 (line low at that moment), with a second word queued
        rx_q.delete();
        rx_starts.delete();
        push(32'h8765_4321);
        push(32'h0F0E_0D0C);
        repeat (BYTE_CYC + 14) @(negedge clk);
        check("rst_mid_bytes_before", rx_q.size(), 1);
        check("rst_mid_line_before", uart_tx, 1'b0);
        check("rst_mid_level_before", fifo_level, 3'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_line", uart_tx, 1'b1);
        check("rst_mid_level", fifo_level, 3'd0);
        check("rst_mid_busy", tx_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        n_starts = rx_starts.size();
        repeat (100) @(negedge clk);
        check("rst_mid_no_bits", rx_starts.size(), n_starts);
        check("rst_mid_no_bytes", rx_q.size(), 1);
        rx_q.delete();
        push(32'hC0FF_EE11);
        wait_bytes(4, WORD_CYC + 20, "post_rst_count");
        words = '{32'hC0FF_EE11};
        check_words(words, "post_rst");
        wait_idle("post_rst_idle");

`ifdef PC_WORD_TX_PARITY_EN
        // Even parity: 07 -> 1, 03 -> 0, 00 -> 0
        rx_q.delete();
        rx_par_q.delete();
        rx_starts.delete();
        push(32'h0000_0307);
        wait_bytes(4, WORD_CYC + 20, "par_count");
        check("par_07", rx_par_q[0], 1'b1);
        check("par_03", rx_par_q[1], 1'b0);
        check("par_00", rx_par_q[2], 1'b0);
        check("par_byte0", rx_q[0], 8'h07);
        check("par_spacing", rx_starts[1] - rx_starts[0], 46);
        wait_idle("par_idle");
`endif

        check("stop_bit_errors", rx_stop_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
